// File: rtl/sp_fifo_pkg.sv
// sp_fifo_pkg: shared helpers for the multi-channel FIFO slice.
// Pointer wrap, width helpers and the parameter legality check macro.
`ifndef SP_FIFO_PKG_SV
`define SP_FIFO_PKG_SV

`define SP_FIFO_CHECK(cond, msg) \
   if (!(cond)) begin : g_param_err \
      $error(msg); \
   end

package sp_fifo_pkg;

   // Advance a pointer, wrapping at the last slot (depth need not be 2^n)
   function automatic int wrap_inc(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

   // Bits needed to hold an occupancy of 0..depth
   function automatic int cnt_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   // Index width, never narrower than one bit
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`endif

// File: rtl/multi_chan_fifo_if.sv
// multi_chan_fifo_if: shared write/read handshake of the channel FIFO.
// master drives requests, slave is the FIFO itself.
interface multi_chan_fifo_if #(
   parameter int CH_W  = 2,
   parameter int WIDTH = 32
) ();
   logic             w_valid;
   logic [CH_W-1:0]  w_ch;
   logic [WIDTH-1:0] w_data;
   logic             w_ready;
   logic             r_ready;
   logic [CH_W-1:0]  r_ch;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   modport master (
      output w_valid, w_ch, w_data, r_ready, r_ch,
      input  w_ready, r_valid, r_data
   );

   modport slave (
      input  w_valid, w_ch, w_data, r_ready, r_ch,
      output w_ready, r_valid, r_data
   );
endinterface

// File: rtl/fifo_chan_ctrl.sv
// fifo_chan_ctrl: pointers, occupancy and status flags of one channel.
// Full/empty come from the count; flush clears the channel in one cycle.
module fifo_chan_ctrl
   import sp_fifo_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int AFULL_TH = 3,
   localparam int PTR_W   = idx_width(DEPTH),
   localparam int CNT_W   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             almost_full
);

   assign empty       = (count == '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign almost_full = (32'(count) >= AFULL_TH);

   // Pointer and occupancy update; reset and flush both clear the channel
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
         if (pop)
            rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/multi_chan_fifo.sv
// multi_chan_fifo: NUM_CH independent FWFT queues behind one write/read port.
// Optional MULTI_CHAN_FIFO_BYPASS_EN: zero-latency write-to-read on an empty channel.
module multi_chan_fifo
   import sp_fifo_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DEPTH    = 4,
   parameter int WIDTH    = 32,
   parameter int AFULL_TH = DEPTH - 1,
   localparam int CH_W    = idx_width(NUM_CH),
   localparam int CNT_W   = cnt_width(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   multi_chan_fifo_if.slave        bus,
   input  logic [NUM_CH-1:0]       flush,
   output logic [NUM_CH-1:0]       empty,
   output logic [NUM_CH-1:0]       full,
   output logic [NUM_CH-1:0]       almost_full,
   output logic [NUM_CH*CNT_W-1:0] count
);

   localparam int PTR_W = idx_width(DEPTH);
   localparam int AW    = idx_width(NUM_CH * DEPTH);

   `SP_FIFO_CHECK(NUM_CH >= 1 && DEPTH >= 1 && AFULL_TH >= 1 && AFULL_TH <= DEPTH,
                  "multi_chan_fifo: illegal NUM_CH/DEPTH/AFULL_TH")

   logic [WIDTH-1:0] mem [NUM_CH*DEPTH];
   logic [PTR_W-1:0] wr_ptr_a [NUM_CH];
   logic [PTR_W-1:0] rd_ptr_a [NUM_CH];

   logic            w_ok, r_ok;
   logic [CH_W-1:0] w_idx, r_idx;
   logic            w_rdy, head_ok, byp;
   logic            do_push, store, do_pop;
   logic [AW-1:0]   waddr, raddr;

   // Out-of-range indices are steered to channel 0 but never qualified
   assign w_ok  = 32'(bus.w_ch) < NUM_CH;
   assign r_ok  = 32'(bus.r_ch) < NUM_CH;
   assign w_idx = w_ok ? bus.w_ch : '0;
   assign r_idx = r_ok ? bus.r_ch : '0;

   assign w_rdy   = w_ok && !full[w_idx] && !flush[w_idx];
   assign head_ok = r_ok && !empty[r_idx] && !flush[r_idx];
   assign do_push = bus.w_valid && w_rdy;
   assign do_pop  = head_ok && bus.r_ready;

`ifdef MULTI_CHAN_FIFO_BYPASS_EN
   assign byp   = bus.w_valid && w_ok && r_ok && (bus.w_ch == bus.r_ch)
                  && empty[r_idx] && !flush[r_idx];
   assign store = do_push && !(byp && bus.r_ready);
`else
   assign byp   = 1'b0;
   assign store = do_push;
`endif

   assign bus.w_ready = w_rdy;
   assign bus.r_valid = head_ok || byp;

   assign waddr = AW'(32'(w_idx) * DEPTH + 32'(wr_ptr_a[w_idx]));
   assign raddr = AW'(32'(r_idx) * DEPTH + 32'(rd_ptr_a[r_idx]));

   // Head mux: stored entry first, bypassed write data second, else zero
   always_comb begin
      bus.r_data = '0;
      if (head_ok)
         bus.r_data = mem[raddr];
      else if (byp)
         bus.r_data = bus.w_data;
   end

   // Storage write; entries are never cleared, only pointers move
   always_ff @(posedge clk) begin
      if (store)
         mem[waddr] <= bus.w_data;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] cnt;

      fifo_chan_ctrl #(
         .DEPTH    (DEPTH),
         .AFULL_TH (AFULL_TH)
      ) u_ctrl (
         .clk         (clk),
         .rst         (rst),
         .push        (store && (w_idx == CH_W'(c))),
         .pop         (do_pop && (r_idx == CH_W'(c))),
         .flush       (flush[c]),
         .wr_ptr      (wr_ptr_a[c]),
         .rd_ptr      (rd_ptr_a[c]),
         .count       (cnt),
         .empty       (empty[c]),
         .full        (full[c]),
         .almost_full (almost_full[c])
      );

      assign count[c*CNT_W +: CNT_W] = cnt;
   end

endmodule
